// File: rtl/arith_arbiter.sv
// ---------------------------------------------------------------------------
// arith_arbiter
//
// Shares a single Arithmetic_Unit between NUM_REQ requesters. One request is
// in flight at a time: a round-robin winner is accepted in IDLE, its opcode
// and operands are driven (registered) onto au_*, the block waits AU_LATENCY
// cycles, captures au_result and presents it on the rsp_* channel until the
// consumer takes it.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   OPCODE_L    opcode width (00 add, 01 sub, 10 mul, 11 div)
//   OPERAND_L   operand width
//   RES_L       result width
//   AU_LATENCY  clk edges from au_* change to au_result valid (1..15)
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   req_valid / req_ready           per-requester handshake (ready is
//                                   combinational, at most one bit high)
//   req_opcode/operand1/operand2    packed per-requester request fields,
//                                   requester i at slice i
//   au_opcode/operand1/operand2     registered drive to the Arithmetic_Unit
//   au_result                       result returned by the Arithmetic_Unit
//   rsp_valid / rsp_ready           response handshake
//   rsp_id, rsp_result, rsp_err     requester index, result, div-by-zero flag
//   busy                            high whenever the FSM is not IDLE
//
// Build option
//   ARB_DIVZERO_CHECK_EN  when defined, an accepted divide with operand2 == 0
//                         is not issued; it is answered immediately with an
//                         all-ones result and rsp_err = 1. When undefined,
//                         every request is issued and rsp_err is tied to 0.
// ---------------------------------------------------------------------------
module arith_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int OPCODE_L   = 2,
    parameter int OPERAND_L  = 32,
    parameter int RES_L      = 32,
    parameter int AU_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*OPCODE_L-1:0]    req_opcode,
    input  logic [NUM_REQ*OPERAND_L-1:0]   req_operand1,
    input  logic [NUM_REQ*OPERAND_L-1:0]   req_operand2,
    output logic [OPCODE_L-1:0]            au_opcode,
    output logic [OPERAND_L-1:0]           au_operand1,
    output logic [OPERAND_L-1:0]           au_operand2,
    input  logic [RES_L-1:0]               au_result,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic [RES_L-1:0]               rsp_result,
    output logic                           rsp_err,
    output logic                           busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [ID_W-1:0]        last_grant_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [OPCODE_L-1:0]    au_opcode_reg;
    logic [OPERAND_L-1:0]   au_operand1_reg;
    logic [OPERAND_L-1:0]   au_operand2_reg;
    logic [ID_W-1:0]        rsp_id_reg;
    logic [RES_L-1:0]       rsp_result_reg;

    // Unpacked views of the per-requester request fields.
    logic [OPCODE_L-1:0]    opcode_arr   [NUM_REQ];
    logic [OPERAND_L-1:0]   operand1_arr [NUM_REQ];
    logic [OPERAND_L-1:0]   operand2_arr [NUM_REQ];

    logic                   grant_found;
    logic [ID_W-1:0]        grant_idx;
    int                     cand;
    logic                   accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign opcode_arr[gi]   = req_opcode[gi*OPCODE_L +: OPCODE_L];
            assign operand1_arr[gi] = req_operand1[gi*OPERAND_L +: OPERAND_L];
            assign operand2_arr[gi] = req_operand2[gi*OPERAND_L +: OPERAND_L];
        end
    endgenerate

    // Round-robin search: start one past the last grant and wrap. When a
    // single requester is valid it always wins, so it is never held off.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(last_grant_reg) + 1 + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign accept = (state_reg == IDLE) && grant_found;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
        end
    endgenerate

`ifdef ARB_DIVZERO_CHECK_EN
    logic div_zero;
    logic rsp_err_reg;

    assign div_zero = (opcode_arr[grant_idx] == {OPCODE_L{1'b1}}) &&
                      (operand2_arr[grant_idx] == '0);
    assign rsp_err  = rsp_err_reg;
`else
    assign rsp_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
`ifdef ARB_DIVZERO_CHECK_EN
                    state_next = div_zero ? RESP : WAIT;
`else
                    state_next = WAIT;
`endif
                end
            end
            WAIT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: issue registers, latency counter and response capture.
    // A reset at any point simply wipes the in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg  <= ID_W'(NUM_REQ - 1);
            cnt_reg         <= '0;
            au_opcode_reg   <= '0;
            au_operand1_reg <= '0;
            au_operand2_reg <= '0;
            rsp_id_reg      <= '0;
            rsp_result_reg  <= '0;
`ifdef ARB_DIVZERO_CHECK_EN
            rsp_err_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        last_grant_reg <= grant_idx;
                        rsp_id_reg     <= grant_idx;
`ifdef ARB_DIVZERO_CHECK_EN
                        if (div_zero) begin
                            // Answer locally; the AU keeps its previous inputs.
                            rsp_result_reg <= '1;
                            rsp_err_reg    <= 1'b1;
                        end else begin
                            au_opcode_reg   <= opcode_arr[grant_idx];
                            au_operand1_reg <= operand1_arr[grant_idx];
                            au_operand2_reg <= operand2_arr[grant_idx];
                            cnt_reg         <= CNT_W'(AU_LATENCY);
                            rsp_err_reg     <= 1'b0;
                        end
`else
                        au_opcode_reg   <= opcode_arr[grant_idx];
                        au_operand1_reg <= operand1_arr[grant_idx];
                        au_operand2_reg <= operand2_arr[grant_idx];
                        cnt_reg         <= CNT_W'(AU_LATENCY);
`endif
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        rsp_result_reg <= au_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign au_opcode   = au_opcode_reg;
    assign au_operand1 = au_operand1_reg;
    assign au_operand2 = au_operand2_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_result  = rsp_result_reg;
    assign rsp_valid   = (state_reg == RESP);
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_arith_arbiter.sv
// ---------------------------------------------------------------------------
// tb_arith_arbiter
//
// Directed bench for arith_arbiter (4 requesters, AU latency 3). A simple
// combinational Arithmetic_Unit model answers au_*. Stimulus pushes the
// expected response into a queue; a monitor process pops and compares on
// every rsp handshake. The main process also checks reset values, latency,
// hold behaviour in RESP and reset abort.
// ---------------------------------------------------------------------------
module tb_arith_arbiter;

    localparam int N   = 4;
    localparam int OL  = 2;
    localparam int DL  = 32;
    localparam int RL  = 32;
    localparam int LAT = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*OL-1:0]   req_opcode;
    logic [N*DL-1:0]   req_operand1;
    logic [N*DL-1:0]   req_operand2;
    logic [OL-1:0]     au_opcode;
    logic [DL-1:0]     au_operand1;
    logic [DL-1:0]     au_operand2;
    logic [RL-1:0]     au_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [RL-1:0]     rsp_result;
    logic              rsp_err;
    logic              busy;

    arith_arbiter #(
        .NUM_REQ    (N),
        .OPCODE_L   (OL),
        .OPERAND_L  (DL),
        .RES_L      (RL),
        .AU_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_operand1 (req_operand1),
        .req_operand2 (req_operand2),
        .au_opcode    (au_opcode),
        .au_operand1  (au_operand1),
        .au_operand2  (au_operand2),
        .au_result    (au_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic_Unit model: result is a pure function of the au_* inputs,
    // so it is settled well before the arbiter samples it.
    always_comb begin
        case (au_opcode)
            OP_ADD:  au_result = au_operand1 + au_operand2;
            OP_SUB:  au_result = au_operand1 - au_operand2;
            OP_MUL:  au_result = au_operand1 * au_operand2;
            default: au_result = (au_operand2 == '0) ? '1 : au_operand1 / au_operand2;
        endcase
    end

    typedef struct {
        logic [1:0]    id;
        logic [RL-1:0] res;
        logic          err;
    } exp_t;

    exp_t         exp_q[$];
    int           total;
    int           bad;
    logic [N-1:0] last_snap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_opcode[i*OL +: OL]   = op;
        req_operand1[i*DL +: DL] = a;
        req_operand2[i*DL +: DL] = b;
        req_valid[i]             = 1'b1;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [31:0] res, input logic err);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // One clock: check ready legality at the falling edge, then drop the
    // valid of whichever requester was accepted on the rising edge.
    task automatic tick();
        @(negedge clk);
        last_snap = req_ready;
        chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
        if (busy) begin
            chk("ready_when_busy", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (last_snap[i]) begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((req_valid != '0 || busy || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(n < 200), 64'd1);
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_rsp_timeout"}, 64'(n < 50), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Response monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_id), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_result", 64'(rsp_result), 64'(e.res));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    $display("rsp: id=%0d result=%0d err=%0d", rsp_id, rsp_result, rsp_err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        req_valid    = '0;
        req_opcode   = '0;
        req_operand1 = '0;
        req_operand2 = '0;
        rsp_ready    = 1'b0;
        last_snap    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_au_opcode", 64'(au_opcode), 64'd0);
        chk("rst_au_op1", 64'(au_operand1), 64'd0);
        chk("rst_au_op2", 64'(au_operand2), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;

        // Single requester, add 20+20, latency measured in edges
        rsp_ready = 1'b1;
        set_req(0, OP_ADD, 32'd20, 32'd20);
        push_exp(2'd0, 32'd40, 1'b0);
        tick();
        chk("t1_grant", 64'(last_snap), 64'b0001);
        chk("t1_au_op1", 64'(au_operand1), 64'd20);
        chk("t1_ready_after", 64'(req_ready), 64'd0);
        edges = 1;
        while (!rsp_valid && edges < 40) begin
            tick();
            edges++;
        end
        chk("t1_latency", 64'(edges), 64'(LAT + 1));
        wait_idle("t1");
        $display("txn: single add done");

        // All four valid after reset: grants 0,1,2,3
        do_reset();
        set_req(0, OP_SUB, 32'd20, 32'd20);
        set_req(1, OP_MUL, 32'd20, 32'd20);
        set_req(2, OP_DIV, 32'd20, 32'd20);
        set_req(3, OP_ADD, 32'd20, 32'd20);
        push_exp(2'd0, 32'd0, 1'b0);
        push_exp(2'd1, 32'd400, 1'b0);
        push_exp(2'd2, 32'd1, 1'b0);
        push_exp(2'd3, 32'd40, 1'b0);
        wait_idle("t2");
        $display("txn: four-way round robin done");

        // Response held in RESP while a new request waits
        rsp_ready = 1'b0;
        set_req(2, OP_MUL, 32'd7, 32'd6);
        push_exp(2'd2, 32'd42, 1'b0);
        wait_rsp("t3");
        set_req(1, OP_SUB, 32'd50, 32'd5);
        push_exp(2'd1, 32'd45, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t3_hold_id", 64'(rsp_id), 64'd2);
            chk("t3_hold_result", 64'(rsp_result), 64'd42);
            chk("t3_hold_ready", 64'(req_ready), 64'd0);
            chk("t3_hold_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle("t3");
        $display("txn: backpressure hold done");

        // last_grant = 1 -> requester 3 beats requester 1
        set_req(1, OP_ADD, 32'd1, 32'd2);
        push_exp(2'd1, 32'd3, 1'b0);
        wait_idle("t4a");
        set_req(1, OP_ADD, 32'd5, 32'd5);
        set_req(3, OP_SUB, 32'd9, 32'd4);
        push_exp(2'd3, 32'd5, 1'b0);
        push_exp(2'd1, 32'd10, 1'b0);
        wait_idle("t4");
        $display("txn: wrap priority done");

        // Reset during WAIT discards the request
        set_req(0, OP_ADD, 32'd100, 32'd1);
        tick();
        chk("t5_grant", 64'(last_snap), 64'b0001);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_au_op1", 64'(au_operand1), 64'd0);
        chk("t5_rsp_result", 64'(rsp_result), 64'd0);
        chk("t5_rsp_id", 64'(rsp_id), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            tick();
            chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
        end
        set_req(0, OP_ADD, 32'd3, 32'd4);
        set_req(1, OP_ADD, 32'd1, 32'd1);
        push_exp(2'd0, 32'd7, 1'b0);
        push_exp(2'd1, 32'd2, 1'b0);
        wait_idle("t5");
        $display("txn: reset abort done");

        // Divide by zero (last issue was add 1,1 from requester 1)
        set_req(0, OP_DIV, 32'd20, 32'd0);
`ifdef ARB_DIVZERO_CHECK_EN
        push_exp(2'd0, 32'hFFFF_FFFF, 1'b1);
        tick();
        chk("t6_direct_resp", 64'(rsp_valid), 64'd1);
        chk("t6_au_opcode", 64'(au_opcode), 64'(OP_ADD));
        chk("t6_au_op1", 64'(au_operand1), 64'd1);
        chk("t6_au_op2", 64'(au_operand2), 64'd1);
`else
        push_exp(2'd0, 32'hFFFF_FFFF, 1'b0);
        tick();
        chk("t6_au_opcode", 64'(au_opcode), 64'(OP_DIV));
        chk("t6_au_op1", 64'(au_operand1), 64'd20);
        chk("t6_au_op2", 64'(au_operand2), 64'd0);
`endif
        wait_idle("t6");
        $display("txn: divide by zero done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arith_arbiter.md
ARITH_ARBITER -- requirements
Module: arith_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one Arithmetic_Unit (range 2..8).
REQ-002 The block SHALL have parameter OPCODE_L, default 2, meaning the opcode width (00 add, 01 sub, 10 mul, 11 div).
REQ-003 The block SHALL have parameter OPERAND_L, default 32, meaning the operand width.
REQ-004 The block SHALL have parameter RES_L, default 32, meaning the result width.
REQ-005 The block SHALL have parameter AU_LATENCY, default 1, meaning the number of clk edges from au_* operands changing to au_result being valid (range 1..15).
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset, with ports: clk input 1 system clock; rst input 1 asynchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, width NUM_REQ: per-requester request valid.
REQ-008 The block SHALL have port req_ready, output, width NUM_REQ: per-requester accept, combinational, at most one bit high.
REQ-009 The block SHALL have port req_opcode, input, width NUM_REQ*OPCODE_L: opcodes, requester i at slice i.
REQ-010 The block SHALL have ports req_operand1 and req_operand2, input, width NUM_REQ*OPERAND_L each: operands, requester i at slice i.
REQ-011 The block SHALL have ports au_opcode, au_operand1 and au_operand2, output, widths OPCODE_L/OPERAND_L/OPERAND_L: registered drive to the Arithmetic_Unit.
REQ-012 The block SHALL have port au_result, input, width RES_L: result from the Arithmetic_Unit.
REQ-013 The block SHALL have port rsp_valid, output, width 1: response valid.
REQ-014 The block SHALL have port rsp_ready, input, width 1: response consumer ready.
REQ-015 The block SHALL have port rsp_id, output, width $clog2(NUM_REQ): requester index of the response.
REQ-016 The block SHALL have port rsp_result, output, width RES_L: registered result.
REQ-017 The block SHALL have port rsp_err, output, width 1: divide-by-zero flag.
REQ-018 The block SHALL have port busy, output, width 1: high whenever the state is not IDLE.

Function
REQ-019 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-020 In IDLE with any req_valid high, the block SHALL assert req_ready only for the round-robin winner in that same cycle, and on the next edge SHALL load au_*, rsp_id and the latency counter (AU_LATENCY) and go to WAIT.
REQ-021 Round-robin priority SHALL start at (last_grant+1) mod NUM_REQ and search upward with wrap-around; last_grant SHALL update on every accept.
REQ-022 WAIT SHALL decrement the counter each cycle; in the cycle the counter equals 1, the block SHALL register au_result into rsp_result on the edge and go to RESP.
REQ-023 RESP SHALL hold rsp_valid=1 with stable rsp_id, rsp_result and rsp_err until rsp_ready=1, then go to IDLE on that edge.
REQ-024 req_ready SHALL be 0 in WAIT and RESP; requests arriving then SHALL wait and never be dropped.
REQ-025 A request SHALL be accepted only in IDLE, giving a minimum issue interval of AU_LATENCY+2 cycles.
REQ-026 au_* outputs SHALL hold their last issued values outside IDLE-accept edges.
REQ-027 With a single requester continuously valid, that requester SHALL be granted on every IDLE cycle (no bubble imposed by fairness).

Reset
REQ-028 rst high SHALL asynchronously force state=IDLE, last_grant=NUM_REQ-1 (requester 0 highest priority), counter=0, au_* and rsp_result to all-zero, rsp_id=0, rsp_err=0, rsp_valid=0 and busy=0.
REQ-029 A reset asserted mid-operation SHALL discard the in-flight request without producing a response.

Configuration
REQ-030 With macro ARB_DIVZERO_CHECK_EN defined, an accepted opcode 11 with operand2==0 SHALL NOT be issued: au_* SHALL stay unchanged, the block SHALL go directly to RESP on the accept edge with rsp_result all-ones and rsp_err=1.
REQ-031 With ARB_DIVZERO_CHECK_EN undefined, all requests SHALL be issued normally and rsp_err SHALL be tied 0.

Verification
REQ-032 The bench SHALL cover: req 0 only, add 20+20 -> req_ready[0] one cycle, rsp_valid after AU_LATENCY+1 edges, rsp_id=0, rsp_result=40.
REQ-033 The bench SHALL cover: all four valid after reset, ops sub/mul/div/add on 20,20 -> grants in order 0,1,2,3; results 0,400,1,40.
REQ-034 The bench SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready all 0, busy=1.
REQ-035 The bench SHALL cover: reqs 1 and 3 valid with last_grant=1 -> req 3 granted first, then req 1.
REQ-036 The bench SHALL cover: rst asserted in WAIT -> rsp_valid never asserts, outputs at reset values, next grant goes to req 0.
REQ-037 The bench SHALL cover: with ARB_DIVZERO_CHECK_EN, div 20/0 -> rsp_err=1, rsp_result=0xFFFFFFFF, au_* unchanged.
